// File: rtl/mac_seq_ctrl.sv
// mac_seq_ctrl: sequences a MAC lane array through clear, operand streaming, drain and result capture.
// Ports: clk/rst (async, active-high); start/vec_len/ch_mask job request; abort cancel;
// in_valid/in_ready/in_data/in_weight operand stream; mac_enable/mac_clear/mac_input/mac_weight
// array control; mac_valid/mac_overflow/mac_out array status; res_valid/res_ready/res_data/
// res_overflow/res_err result channel; busy/done status.
module mac_seq_ctrl #(
    parameter int NUM_CHANNELS = 4,
    parameter int DATA_WIDTH   = 8,
    parameter int OUTPUT_WIDTH = 16,
    parameter int LEN_WIDTH    = 8,
    parameter int MAC_LATENCY  = 2
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic                                 start,
    input  logic [LEN_WIDTH-1:0]                 vec_len,
    input  logic [NUM_CHANNELS-1:0]              ch_mask,
    input  logic                                 abort,
    input  logic                                 in_valid,
    output logic                                 in_ready,
    input  logic [DATA_WIDTH*NUM_CHANNELS-1:0]   in_data,
    input  logic [DATA_WIDTH*NUM_CHANNELS-1:0]   in_weight,
    output logic [NUM_CHANNELS-1:0]              mac_enable,
    output logic [NUM_CHANNELS-1:0]              mac_clear,
    output logic [DATA_WIDTH*NUM_CHANNELS-1:0]   mac_input,
    output logic [DATA_WIDTH*NUM_CHANNELS-1:0]   mac_weight,
    input  logic [NUM_CHANNELS-1:0]              mac_valid,
    input  logic [NUM_CHANNELS-1:0]              mac_overflow,
    input  logic [OUTPUT_WIDTH*NUM_CHANNELS-1:0] mac_out,
    output logic                                 res_valid,
    input  logic                                 res_ready,
    output logic [OUTPUT_WIDTH*NUM_CHANNELS-1:0] res_data,
    output logic [NUM_CHANNELS-1:0]              res_overflow,
    output logic                                 res_err,
    output logic                                 busy,
    output logic                                 done
);
    typedef enum logic [2:0] {IDLE, CLEAR, STREAM, DRAIN, RESULT} state_t;
    state_t state_q, state_d;
    logic [LEN_WIDTH-1:0] len_q, len_d, cnt_q, cnt_d;
    logic [NUM_CHANNELS-1:0] mask_q, mask_d, en_q, en_d, clr_q, clr_d, ovf_q, ovf_d;
    logic [DATA_WIDTH*NUM_CHANNELS-1:0] din_q, din_d, wt_q, wt_d;
    logic [OUTPUT_WIDTH*NUM_CHANNELS-1:0] rdata_q, rdata_d, lane_mask;
    logic [3:0] dcnt_q, dcnt_d;
    logic err_q, err_d, done_q, done_d;
    for (genvar i = 0; i < NUM_CHANNELS; i++) begin : g_lane
        assign lane_mask[i*OUTPUT_WIDTH +: OUTPUT_WIDTH] = {OUTPUT_WIDTH{mask_q[i]}};
    end
    always_comb begin
        state_d = state_q;
        len_d   = len_q;
        mask_d  = mask_q;
        cnt_d   = cnt_q;
        dcnt_d  = dcnt_q;
        en_d    = '0;
        clr_d   = '0;
        din_d   = din_q;
        wt_d    = wt_q;
        rdata_d = rdata_q;
        ovf_d   = ovf_q;
        err_d   = err_q;
        done_d  = 1'b0;
        if (abort && state_q != IDLE) begin
            state_d = IDLE;
            clr_d   = '1;
            err_d   = 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    // A rejected request reports res_err alongside its done pulse for one cycle only.
                    err_d = 1'b0;
                    if (start && vec_len != '0 && ch_mask != '0) begin
                        len_d   = vec_len;
                        mask_d  = ch_mask;
                        cnt_d   = '0;
                        clr_d   = ch_mask;
                        state_d = CLEAR;
                    end else if (start) begin
                        done_d = 1'b1;
                        err_d  = 1'b1;
                    end
                end
                CLEAR: state_d = STREAM;
                STREAM: begin
                    if (in_valid) begin
                        en_d  = mask_q;
                        din_d = in_data;
                        wt_d  = in_weight;
                        cnt_d = cnt_q + 1'b1;
                        // Compare against len-1 so a full-range length never needs a wider counter.
                        if (cnt_q == len_q - 1'b1) begin
                            dcnt_d  = '0;
                            state_d = DRAIN;
                        end
                    end
                end
                DRAIN: begin
                    // DRAIN starts on the cycle carrying the last enable and spans MAC_LATENCY cycles.
                    if (dcnt_q == 4'(MAC_LATENCY - 1)) begin
                        rdata_d = mac_out & lane_mask;
                        ovf_d   = mac_overflow & mask_q;
                        err_d   = (mac_valid & mask_q) != mask_q;
                        state_d = RESULT;
                    end else begin
                        dcnt_d = dcnt_q + 4'd1;
                    end
                end
                RESULT: begin
                    if (res_ready) begin
                        done_d  = 1'b1;
                        state_d = IDLE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            len_q   <= '0;
            mask_q  <= '0;
            cnt_q   <= '0;
            dcnt_q  <= '0;
            en_q    <= '0;
            clr_q   <= '0;
            din_q   <= '0;
            wt_q    <= '0;
            rdata_q <= '0;
            ovf_q   <= '0;
            err_q   <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            len_q   <= len_d;
            mask_q  <= mask_d;
            cnt_q   <= cnt_d;
            dcnt_q  <= dcnt_d;
            en_q    <= en_d;
            clr_q   <= clr_d;
            din_q   <= din_d;
            wt_q    <= wt_d;
            rdata_q <= rdata_d;
            ovf_q   <= ovf_d;
            err_q   <= err_d;
            done_q  <= done_d;
        end
    end
    assign in_ready     = state_q == STREAM;
    assign busy         = state_q != IDLE;
    assign res_valid    = state_q == RESULT;
    assign mac_enable   = en_q;
    assign mac_clear    = clr_q;
    assign mac_input    = din_q;
    assign mac_weight   = wt_q;
    assign res_data     = rdata_q;
    assign res_overflow = ovf_q;
    assign res_err      = err_q;
    assign done         = done_q;
endmodule

// File: tb/tb_mac_seq_ctrl.sv
// tb_mac_seq_ctrl: directed scoreboard bench for mac_seq_ctrl with default parameters.
module tb_mac_seq_ctrl;
    localparam int LAT = 2;
    logic clk = 1'b0, rst = 1'b1;
    logic start = 1'b0, abort = 1'b0, in_valid = 1'b0, res_ready = 1'b0;
    logic [7:0] vec_len = '0;
    logic [3:0] ch_mask = '0, mac_valid = '0, mac_overflow = '0;
    logic [31:0] in_data = '0, in_weight = '0;
    logic [63:0] mac_out = '0;
    logic in_ready, res_valid, res_err, busy, done;
    logic [3:0] mac_enable, mac_clear, res_overflow;
    logic [31:0] mac_input, mac_weight;
    logic [63:0] res_data;
    int vectors = 0, miscompares = 0;
    typedef struct {
        logic [63:0] d;
        logic [3:0]  o;
        logic        e;
    } exp_t;
    exp_t sb[$];

    mac_seq_ctrl dut (
        .clk(clk), .rst(rst), .start(start), .vec_len(vec_len), .ch_mask(ch_mask), .abort(abort),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_weight(in_weight),
        .mac_enable(mac_enable), .mac_clear(mac_clear), .mac_input(mac_input), .mac_weight(mac_weight),
        .mac_valid(mac_valid), .mac_overflow(mac_overflow), .mac_out(mac_out),
        .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data), .res_overflow(res_overflow),
        .res_err(res_err), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic stream(input int n, input logic [3:0] mask, input bit gaps);
        int sent = 0;
        int k = 0;
        bit hs;
        logic [31:0] d, w;
        while (sent < n && k < 2 * n + 2) begin
            hs = gaps ? (k % 2 == 0) : 1'b1;
            d = $urandom;
            w = $urandom;
            in_valid = hs;
            in_data = d;
            in_weight = w;
            chk("in_ready", in_ready, 1);
            tick();
            chk("enable", mac_enable, hs ? mask : 4'h0);
            if (hs) begin
                chk("mac_input", mac_input, d);
                chk("mac_weight", mac_weight, w);
                sent++;
            end
            k++;
        end
        in_valid = 1'b0;
        chk("ready_drop", in_ready, 0);
    endtask

    task automatic job(input logic [7:0] len, input logic [3:0] mask, input bit gaps,
                       input logic [3:0] vld, input logic [3:0] ov, input logic [63:0] mo, input int hold);
        exp_t e, got;
        mac_out = mo;
        mac_valid = vld;
        mac_overflow = ov;
        for (int c = 0; c < 4; c++) e.d[c*16 +: 16] = mask[c] ? mo[c*16 +: 16] : 16'h0;
        e.o = ov & mask;
        e.e = (vld & mask) != mask;
        sb.push_back(e);
        start = 1'b1;
        vec_len = len;
        ch_mask = mask;
        res_ready = 1'b0;
        tick();
        start = 1'b0;
        chk("clear", mac_clear, mask);
        chk("clear_en", mac_enable, 0);
        chk("clear_rdy", in_ready, 0);
        chk("busy", busy, 1);
        tick();
        chk("clear_off", mac_clear, 0);
        stream(len, mask, gaps);
        for (int i = 1; i < LAT; i++) begin
            tick();
            chk("drain_rv", res_valid, 0);
            chk("drain_en", mac_enable, 0);
        end
        tick();
        chk("res_valid", res_valid, 1);
        if (sb.size() == 0) begin
            chk("sb_empty", 1, 0);
        end else begin
            got = sb.pop_front();
            chk("res_data", res_data, got.d);
            chk("res_ovf", res_overflow, got.o);
            chk("res_err", res_err, got.e);
            for (int h = 0; h < hold; h++) begin
                start = (h % 2 == 0);
                vec_len = 8'd1;
                ch_mask = 4'h1;
                tick();
                chk("hold_valid", res_valid, 1);
                chk("hold_data", res_data, got.d);
                chk("hold_err", res_err, got.e);
                chk("hold_busy", busy, 1);
                chk("hold_done", done, 0);
            end
        end
        start = 1'b0;
        res_ready = 1'b1;
        tick();
        res_ready = 1'b0;
        chk("done", done, 1);
        chk("rv_drop", res_valid, 0);
        chk("idle", busy, 0);
        tick();
        chk("done_pulse", done, 0);
        chk("still_idle", busy, 0);
    endtask

    initial begin
        tick();
        tick();
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_rdy", in_ready, 0);
        chk("rst_en", mac_enable, 0);
        chk("rst_clr", mac_clear, 0);
        chk("rst_in", mac_input, 0);
        chk("rst_wt", mac_weight, 0);
        chk("rst_rv", res_valid, 0);
        chk("rst_data", res_data, 0);
        chk("rst_ovf", res_overflow, 0);
        chk("rst_err", res_err, 0);
        rst = 1'b0;
        tick();
        job(8'd3, 4'hF, 1'b0, 4'hF, 4'h0, 64'h1111_2222_3333_4444, 0);
        job(8'd4, 4'hF, 1'b1, 4'hF, 4'h5, 64'h0123_4567_89AB_CDEF, 0);
        job(8'd3, 4'b0101, 1'b0, 4'b0101, 4'hF, 64'hABCD_ABCD_ABCD_ABCD, 5);
        job(8'd4, 4'hF, 1'b0, 4'b0011, 4'h2, 64'hDEAD_BEEF_CAFE_F00D, 0);
        job(8'd255, 4'hF, 1'b0, 4'hF, 4'h8, 64'h5555_AAAA_0F0F_F0F0, 0);
        mac_valid = 4'hF;
        start = 1'b1;
        vec_len = 8'd4;
        ch_mask = 4'hF;
        tick();
        start = 1'b0;
        tick();
        in_valid = 1'b1;
        in_data = 32'h0102_0304;
        tick();
        chk("ab_first_en", mac_enable, 4'hF);
        abort = 1'b1;
        start = 1'b1;
        in_data = 32'h0506_0708;
        tick();
        abort = 1'b0;
        start = 1'b0;
        in_valid = 1'b0;
        chk("ab_clear", mac_clear, 4'hF);
        chk("ab_en", mac_enable, 0);
        chk("ab_rdy", in_ready, 0);
        chk("ab_busy", busy, 0);
        chk("ab_rv", res_valid, 0);
        chk("ab_done", done, 0);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("ab_post_done", done, 0);
            chk("ab_post_rv", res_valid, 0);
            chk("ab_post_clr", mac_clear, 0);
        end
        start = 1'b1;
        vec_len = 8'd0;
        ch_mask = 4'hF;
        tick();
        start = 1'b0;
        chk("zl_done", done, 1);
        chk("zl_err", res_err, 1);
        chk("zl_busy", busy, 0);
        chk("zl_rv", res_valid, 0);
        tick();
        chk("zl_done_off", done, 0);
        chk("zl_busy_off", busy, 0);
        start = 1'b1;
        vec_len = 8'd3;
        ch_mask = 4'h0;
        tick();
        start = 1'b0;
        chk("zm_done", done, 1);
        chk("zm_err", res_err, 1);
        chk("zm_busy", busy, 0);
        tick();
        chk("zm_done_off", done, 0);
        start = 1'b1;
        vec_len = 8'd5;
        ch_mask = 4'hF;
        tick();
        start = 1'b0;
        tick();
        in_valid = 1'b1;
        in_data = 32'hFFFF_FFFF;
        tick();
        rst = 1'b1;
        #1;
        chk("mr_busy", busy, 0);
        chk("mr_en", mac_enable, 0);
        chk("mr_rdy", in_ready, 0);
        chk("mr_in", mac_input, 0);
        in_valid = 1'b0;
        tick();
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("mr_done", done, 0);
            chk("mr_idle", busy, 0);
        end
        job(8'd2, 4'b1000, 1'b0, 4'b1000, 4'h8, 64'h7777_0000_0000_0000, 0);
        chk("sb_drained", sb.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
